// File: rtl/ultrasonic_echo_rx_if.sv
// ---------------------------------------------------------------------------
// ultrasonic_echo_rx_if
// Groups the control, echo input and result signals of the echo receiver.
//   start  : one-cycle strobe marking the transmitter burst start
//   rx_in  : asynchronous comparator output of the receive transducer
//   busy   : measurement in progress
//   done   : one-cycle pulse when a measurement finishes
//   hit    : 1 = echo detected, 0 = timeout (held until next done)
//   tof    : time-of-flight in clocks (held until next done)
// master = controller / ranging side, slave = the receiver itself.
// ---------------------------------------------------------------------------
interface ultrasonic_echo_rx_if;
  logic        start;
  logic        rx_in;
  logic        busy;
  logic        done;
  logic        hit;
  logic [23:0] tof;

  modport master (output start, rx_in, input busy, done, hit, tof);
  modport slave  (input start, rx_in, output busy, done, hit, tof);
endinterface

// File: rtl/ultrasonic_echo_rx.sv
// ---------------------------------------------------------------------------
// ultrasonic_echo_rx
// Qualifies a 40 kHz echo burst on the digitised receiver signal and reports
// the time-of-flight from the start strobe to the first edge of the burst.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : ultrasonic_echo_rx_if.slave (start, rx_in, busy, done, hit, tof)
// ---------------------------------------------------------------------------
module ultrasonic_echo_rx #(
  parameter int CLK_PER_CYCLE = 1250,
  parameter int TOL           = 125,
  parameter int MIN_CYCLES    = 4,
  parameter int BLANK_CYC     = 25000,
  parameter int TIMEOUT_CYC   = 1250000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  ultrasonic_echo_rx_if.slave   bus
);

  // Run count must hold 0..MIN_CYCLES+1
  localparam int RW = $clog2(MIN_CYCLES + 2);

  localparam logic [11:0] P_LO         = 12'(CLK_PER_CYCLE - TOL);
  localparam logic [11:0] P_HI         = 12'(CLK_PER_CYCLE + TOL);
  localparam logic [11:0] P_MAX        = 12'hFFF;
  localparam logic [23:0] BLANK_LAST   = 24'(BLANK_CYC - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;

  state_t          state, state_n;
  logic            s1, s2, s3;
  logic            rise;
  logic [11:0]     period_cnt;
  logic            in_tol;
  logic [23:0]     timer, timer_n;
  logic [23:0]     first_edge, first_edge_n;
  logic [RW-1:0]   run_cnt, run_n;
  logic            done_q, done_n;
  logic            hit_q, hit_n;
  logic [23:0]     tof_q, tof_n;
  logic            detect;

  // Two-flop synchroniser plus a history flop; a rise is seen two clocks
  // after rx_in is first sampled high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.rx_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Clocks since the previous rise; saturates so a long gap can never wrap
  // back into the tolerance window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period_cnt <= '0;
    end else if (rise) begin
      period_cnt <= 12'd1;
    end else if (period_cnt != P_MAX) begin
      period_cnt <= period_cnt + 12'd1;
    end
  end

  assign in_tol = (period_cnt >= P_LO) && (period_cnt <= P_HI);

  // State and measurement registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      timer      <= '0;
      first_edge <= '0;
      run_cnt    <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      tof_q      <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      first_edge <= first_edge_n;
      run_cnt    <= run_n;
      done_q     <= done_n;
      hit_q      <= hit_n;
      tof_q      <= tof_n;
    end
  end

  // Next-state logic. A run count of 1 means "armed" on the first edge; each
  // in-tolerance period adds one, so MIN_CYCLES+1 means MIN_CYCLES good
  // periods. Detection is decided on the edge itself so done follows by one
  // clock, and it takes priority over a coincident timeout.
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    first_edge_n = first_edge;
    run_n        = run_cnt;
    done_n       = 1'b0;
    hit_n        = hit_q;
    tof_n        = tof_q;
    detect       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = BLANK;
          timer_n = '0;
          run_n   = '0;
        end
      end
      BLANK: begin
        timer_n = timer + 24'd1;
        run_n   = '0;
        if (timer == BLANK_LAST) state_n = LISTEN;
      end
      LISTEN: begin
        timer_n = timer + 24'd1;
        if (rise) begin
          if (run_cnt == '0) begin
            run_n        = RW'(1);
            first_edge_n = timer;
          end else if (in_tol) begin
            run_n = run_cnt + RW'(1);
            if (run_cnt == RW'(MIN_CYCLES)) detect = 1'b1;
          end else begin
            run_n        = RW'(1);
            first_edge_n = timer;
          end
        end
        if (detect) begin
          state_n = IDLE;
          done_n  = 1'b1;
          hit_n   = 1'b1;
          tof_n   = first_edge;
        end else if (timer == TIMEOUT_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
          hit_n   = 1'b0;
          tof_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hit  = hit_q;
  assign bus.tof  = tof_q;

endmodule

// File: tb/tb_ultrasonic_echo_rx.sv
// ---------------------------------------------------------------------------
// tb_ultrasonic_echo_rx
// Scoreboard bench for ultrasonic_echo_rx with scaled-down timing parameters.
// Each scenario is a sorted list of timer values at which rx_in is first
// sampled high; a list-based reference model predicts hit, tof and the done
// cycle, which a separate monitor compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_ultrasonic_echo_rx;

  localparam int P     = 50;
  localparam int TOL   = 5;
  localparam int MINC  = 4;
  localparam int BLANK = 200;
  localparam int TMO   = 6000;
  localparam int HALF  = P / 2;
  localparam int WLEN  = TMO + 16;

  typedef struct {
    bit hit;
    int tof;
    int at;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   passes = 0;

  int   rises[$];
  int   start_pulses[$];
  int   rst_at;
  logic wave [0:WLEN-1];
  exp_t sb[$];

  ultrasonic_echo_rx_if bus ();

  ultrasonic_echo_rx #(
    .CLK_PER_CYCLE (P),
    .TOL           (TOL),
    .MIN_CYCLES    (MINC),
    .BLANK_CYC     (BLANK),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // 10-unit clock and a free-running cycle stamp
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit inPulses(input int t);
    foreach (start_pulses[i]) if (start_pulses[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clearScenario();
    rises.delete();
    start_pulses.delete();
    rst_at = -1;
  endtask

  task automatic addBurst(input int first, input int period, input int count);
    for (int k = 0; k < count; k++) rises.push_back(first + k * period);
  endtask

  // rx_in waveform: high for half a nominal period after each rise, shortened
  // so it always falls before the next rise.
  task automatic buildWave();
    for (int t = 0; t < WLEN; t++) wave[t] = 1'b0;
    for (int i = 0; i < rises.size(); i++) begin
      int h;
      h = HALF;
      if (i + 1 < rises.size() && (rises[i+1] - rises[i]) / 2 < h)
        h = (rises[i+1] - rises[i]) / 2;
      for (int t = rises[i]; t < rises[i] + h && t < WLEN; t++) wave[t] = 1'b1;
    end
  endtask

  // Reference model: an edge is seen 2 clocks after sampling; only edges with
  // timer in [BLANK, TMO-1] count. Periods between counted edges, capped at
  // 4095, extend or restart the run; MINC good periods give a hit.
  task automatic modelExpect(output bit hit, output int tof, output int done_t);
    int edges[$];
    int run;
    int fe;
    int p;
    for (int i = 0; i < rises.size(); i++)
      if (rises[i] + 2 >= BLANK && rises[i] + 2 <= TMO - 1) edges.push_back(rises[i] + 2);
    run = 0; fe = 0; hit = 1'b0; tof = 0; done_t = TMO;
    for (int i = 0; i < edges.size() && !hit; i++) begin
      if (run == 0) begin
        run = 1; fe = edges[i];
      end else begin
        p = edges[i] - edges[i-1];
        if (p > 4095) p = 4095;
        if (p >= P - TOL && p <= P + TOL) begin
          run++;
          if (run == MINC + 1) begin
            hit = 1'b1; tof = fe; done_t = edges[i] + 1;
          end
        end else begin
          run = 1; fe = edges[i];
        end
      end
    end
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    #1;
    checkOutput("rst_mid_busy", bus.busy, 0);
    checkOutput("rst_mid_done", bus.done, 0);
    checkOutput("rst_mid_hit",  bus.hit, 0);
    checkOutput("rst_mid_tof",  bus.tof, 0);
    bus.start = 1'b0;
    bus.rx_in = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("rst_after_busy", bus.busy, 0);
    checkOutput("rst_after_hit",  bus.hit, 0);
  endtask

  // Runs one measurement from the current scenario. chained_in: start was
  // already accepted on the previous edge. chain_out: pulse start in the
  // done cycle and return right after it is accepted.
  task automatic applyStimulus(input bit chained_in, input bit chain_out);
    bit eh;
    int et, ed, n0;
    buildWave();
    modelExpect(eh, et, ed);
    if (!chained_in) begin
      bus.start = 1'b1;
      @(posedge CLK);
      #1 bus.start = 1'b0;
    end
    n0 = cyc;
    checkOutput("busy_after_start", bus.busy, 1);
    if (rst_at < 0) sb.push_back('{eh, et, n0 + ed});
    for (int t = 0; t <= ed + 2; t++) begin
      bus.rx_in = (t < ed && t < WLEN) ? wave[t] : 1'b0;
      bus.start = inPulses(t) || (chain_out && t == ed);
      if (t == rst_at) begin
        doReset();
        return;
      end
      @(posedge CLK);
      #1;
      if (chain_out && t == ed) begin
        bus.start = 1'b0;
        checkOutput("busy_after_chain", bus.busy, 1);
        return;
      end
    end
    bus.start = 1'b0;
    checkOutput("done_seen", sb.size(), 0);
    sb.delete();
    checkOutput("hit_held", bus.hit, eh);
    checkOutput("tof_held", bus.tof, et);
    checkOutput("busy_idle", bus.busy, 0);
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge CLK);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          checkOutput("done_hit",  bus.hit, x.hit);
          checkOutput("done_tof",  bus.tof, x.tof);
          checkOutput("done_time", cyc, x.at);
          checkOutput("done_busy", bus.busy, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int t, np, nc, bc;
    bus.start = 1'b0;
    bus.rx_in = 1'b0;
    rst_at    = -1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_hit",  bus.hit, 0);
    checkOutput("reset_tof",  bus.tof, 0);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] clean echo");
    clearScenario(); addBurst(400, P, 6); applyStimulus(0, 0);

    $display("[TB] crosstalk then silence");
    clearScenario(); addBurst(0, P, 4); applyStimulus(0, 0);

    $display("[TB] noise then echo");
    clearScenario(); addBurst(250, 36, 10); addBurst(600, P, 6); applyStimulus(0, 0);

    $display("[TB] tolerance boundaries");
    clearScenario(); addBurst(300, P + TOL, 6);     applyStimulus(0, 0);
    clearScenario(); addBurst(300, P + TOL + 1, 8); applyStimulus(0, 0);
    clearScenario(); addBurst(300, P - TOL, 6);     applyStimulus(0, 0);
    clearScenario(); addBurst(300, P - TOL - 1, 8); applyStimulus(0, 0);

    $display("[TB] start ignored while busy");
    clearScenario(); addBurst(400, P, 6);
    start_pulses.push_back(100); start_pulses.push_back(450);
    applyStimulus(0, 0);

    $display("[TB] reset mid-listen");
    clearScenario(); addBurst(400, P, 6); rst_at = 500; applyStimulus(0, 0);

    $display("[TB] start in done cycle");
    clearScenario(); addBurst(300, P, 5); applyStimulus(0, 1);
    clearScenario(); addBurst(500, P, 5); applyStimulus(1, 0);

    $display("[TB] period counter saturation");
    clearScenario(); rises.push_back(300); addBurst(300 + 4096 + P, P, 5);
    applyStimulus(0, 0);

    $display("[TB] blank and timeout boundaries");
    clearScenario(); addBurst(BLANK - 3, P, 6); applyStimulus(0, 0);
    clearScenario(); addBurst(TMO - 3 - 4 * P, P, 5); applyStimulus(0, 0);

    $display("[TB] random scenarios");
    for (int n = 0; n < 6; n++) begin
      clearScenario();
      t  = $urandom_range(100, 400);
      np = $urandom_range(20, 100);
      nc = $urandom_range(0, 6);
      for (int k = 0; k < nc; k++) begin
        rises.push_back(t);
        t += np;
      end
      t += $urandom_range(0, 60);
      bc = $urandom_range(3, 8);
      for (int k = 0; k < bc; k++) begin
        rises.push_back(t);
        t += 42 + $urandom_range(0, 16);
      end
      applyStimulus(0, 0);
    end

    repeat (3) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
